line_fetch_engine: RTL and testbench

//  Downstream of the write/read control FSMs. Accepts one line-fetch command (fetch_req/fetch_gnt).

---
 rtl/line_fetch_engine_if.sv | 64 ++++++
 rtl/line_fetch_engine.sv | 172 +++++++++++++++++
 tb/tb_line_fetch_engine.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fetch_engine_if.sv
// Signal bundle for line_fetch_engine: fetch command, external line bus and line-memory port.
// master = engine side, slave = environment side.
interface line_fetch_engine_if #(
  parameter int unsigned addr_width = 32,
  parameter int unsigned data_width = 32,
  parameter int unsigned tag_width  = 2,
  parameter int unsigned off_width  = 5
);
  logic                            fetch_req;
  logic                            fetch_gnt;
  logic [1:0]                      fetch_cmd;
  logic [tag_width-1:0]            fetch_tag;
  logic [addr_width-1:0]           fetch_addr;
  logic [addr_width-1:0]           fetch_addr_pre;
  logic                            fetch_done;
  logic                            ext_req_valid;
  logic                            ext_req_ready;
  logic                            ext_req_we;
  logic [addr_width-1:0]           ext_req_addr;
  logic                            ext_wdata_valid;
  logic                            ext_wdata_ready;
  logic [data_width-1:0]           ext_wdata;
  logic                            ext_wdata_last;
  logic                            ext_rdata_valid;
  logic                            ext_rdata_ready;
  logic [data_width-1:0]           ext_rdata;
  logic                            mem_ren;
  logic [tag_width+off_width-1:0]  mem_raddr;
  logic [data_width-1:0]           mem_rdata;
  logic                            mem_wen;
  logic [tag_width+off_width-1:0]  mem_waddr;
  logic [data_width-1:0]           mem_wdata;
  logic                            mem_wready;

  modport master (
    input  fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_addr_pre,
    output fetch_gnt, fetch_done,
    output ext_req_valid, ext_req_we, ext_req_addr,
    input  ext_req_ready,
    output ext_wdata_valid, ext_wdata, ext_wdata_last,
    input  ext_wdata_ready,
    input  ext_rdata_valid, ext_rdata,
    output ext_rdata_ready,
    output mem_ren, mem_raddr,
    input  mem_rdata,
    output mem_wen, mem_waddr, mem_wdata,
    input  mem_wready
  );

  modport slave (
    output fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_addr_pre,
    input  fetch_gnt, fetch_done,
    input  ext_req_valid, ext_req_we, ext_req_addr,
    output ext_req_ready,
    input  ext_wdata_valid, ext_wdata, ext_wdata_last,
    output ext_wdata_ready,
    output ext_rdata_valid, ext_rdata,
    input  ext_rdata_ready,
    input  mem_ren, mem_raddr,
    output mem_rdata,
    input  mem_wen, mem_waddr, mem_wdata,
    output mem_wready
  );
endinterface

// File: rtl/line_fetch_engine.sv
// Line fetch engine: optional writeback of the victim line, then refill into line memory.
// Define FETCH_STATS_EN to add saturating refill/writeback/stall counters.
module line_fetch_engine #(
  parameter int unsigned addr_width = 32,
  parameter int unsigned list_depth = 4,
  parameter int unsigned data_width = 32,
  parameter int unsigned list_width = 32
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_refills,
  output logic [31:0] stat_writebacks,
  output logic [31:0] stat_stall_cycles,
`endif
  line_fetch_engine_if.master bus
);
  localparam int unsigned TW = $clog2(list_depth);
  localparam int unsigned OW = $clog2(list_width);
  localparam logic [OW-1:0] LastBeat = OW'(list_width - 1);
  localparam logic [OW:0]   IssEnd   = (OW+1)'(list_width);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWbReq  = 3'd1;
  localparam logic [2:0] StWbData = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StRdData = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic [addr_width-1:0] addr_q, addr_d, addr_pre_q, addr_pre_d;
  logic [OW-1:0]         rd_cnt_q, rd_cnt_d, wb_cnt_q, wb_cnt_d;
  logic [OW:0]           iss_cnt_q, iss_cnt_d;
  logic [data_width-1:0] fifo_q [2];
  logic [data_width-1:0] fifo_d [2];
  logic                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic                  infl_q, infl_d;

  logic       gnt, in_wb, in_rd, wb_pop, wb_push, rd_acc, ren, wb_last;
  logic [2:0] occ;

  assign gnt     = bus.fetch_req && (state_q == StIdle);
  assign in_wb   = (state_q == StWbData);
  assign in_rd   = (state_q == StRdData);
  assign wb_pop  = in_wb && (fifo_cnt_q != 2'd0) && bus.ext_wdata_ready;
  assign wb_push = infl_q;
  assign wb_last = (wb_cnt_q == LastBeat);
  // Counting the same-cycle pop lets a read issue every cycle while the bus keeps draining.
  assign occ     = 3'(fifo_cnt_q) + 3'(infl_q) - 3'(wb_pop);
  assign ren     = in_wb && (occ < 3'd2) && (iss_cnt_q < IssEnd);
  assign rd_acc  = in_rd && bus.ext_rdata_valid && bus.mem_wready;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tag_d      = tag_q;
    addr_d     = addr_q;
    addr_pre_d = addr_pre_q;
    rd_cnt_d   = rd_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    iss_cnt_d  = iss_cnt_q;
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    infl_d     = ren;
    fifo_cnt_d = fifo_cnt_q + 2'(wb_push) - 2'(wb_pop);
    if (gnt) begin
      cmd_d      = bus.fetch_cmd;
      tag_d      = bus.fetch_tag;
      addr_d     = bus.fetch_addr;
      addr_pre_d = bus.fetch_addr_pre;
      rd_cnt_d   = '0;
      wb_cnt_d   = '0;
      iss_cnt_d  = '0;
      wptr_d     = 1'b0;
      rptr_d     = 1'b0;
      fifo_cnt_d = 2'd0;
    end
    if (ren) iss_cnt_d = iss_cnt_q + 1'b1;
    if (wb_push) begin
      fifo_d[wptr_q] = bus.mem_rdata;
      wptr_d         = ~wptr_q;
    end
    if (wb_pop) begin
      rptr_d   = ~rptr_q;
      wb_cnt_d = wb_cnt_q + 1'b1;
    end
    if (rd_acc) rd_cnt_d = rd_cnt_q + 1'b1;

    unique case (state_q)
      StIdle:   if (gnt) state_d = bus.fetch_cmd[1] ? StWbReq :
                                   bus.fetch_cmd[0] ? StRdReq : StDone;
      StWbReq:  if (bus.ext_req_ready) state_d = StWbData;
      StWbData: if (wb_pop && wb_last) state_d = cmd_q[0] ? StRdReq : StDone;
      StRdReq:  if (bus.ext_req_ready) state_d = StRdData;
      StRdData: if (rd_acc && (rd_cnt_q == LastBeat)) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
      addr_pre_q <= '0;
      rd_cnt_q   <= '0;
      wb_cnt_q   <= '0;
      iss_cnt_q  <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      fifo_cnt_q <= 2'd0;
      infl_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      addr_pre_q <= addr_pre_d;
      rd_cnt_q   <= rd_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      iss_cnt_q  <= iss_cnt_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      infl_q     <= infl_d;
    end
  end

  assign bus.fetch_gnt       = gnt;
  assign bus.fetch_done      = (state_q == StDone);
  assign bus.ext_req_valid   = (state_q == StWbReq) || (state_q == StRdReq);
  assign bus.ext_req_we      = (state_q == StWbReq);
  assign bus.ext_req_addr    = (state_q == StWbReq) ? addr_pre_q :
                               (state_q == StRdReq) ? addr_q : '0;
  assign bus.ext_wdata_valid = in_wb && (fifo_cnt_q != 2'd0);
  assign bus.ext_wdata       = fifo_q[rptr_q];
  assign bus.ext_wdata_last  = bus.ext_wdata_valid && wb_last;
  assign bus.ext_rdata_ready = in_rd && bus.mem_wready;
  assign bus.mem_ren         = ren;
  assign bus.mem_raddr       = {tag_q, iss_cnt_q[OW-1:0]};
  assign bus.mem_wen         = in_rd && bus.ext_rdata_valid;
  assign bus.mem_waddr       = {tag_q, rd_cnt_q};
  assign bus.mem_wdata       = in_rd ? bus.ext_rdata : '0;

`ifdef FETCH_STATS_EN
  logic refill_end, wb_end, stall;
  assign refill_end = rd_acc && (rd_cnt_q == LastBeat);
  assign wb_end     = wb_pop && wb_last;
  assign stall      = (in_rd && !rd_acc) || (in_wb && !wb_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_refills      <= '0;
      stat_writebacks   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (refill_end && (stat_refills != '1))     stat_refills      <= stat_refills + 1'b1;
      if (wb_end && (stat_writebacks != '1))      stat_writebacks   <= stat_writebacks + 1'b1;
      if (stall && (stat_stall_cycles != '1))     stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_line_fetch_engine.sv
// Bench for line_fetch_engine: bus/memory responders plus a line-level reference model
// (expected writeback beats, bus requests and final line-memory image per command).
module tb_line_fetch_engine;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LD = 4;
  localparam int unsigned LW = 32;
  localparam int unsigned TW = 2;
  localparam int unsigned OW = 5;
  localparam int unsigned NW = LD * LW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_fetch_engine_if #(.addr_width(AW), .data_width(DW), .tag_width(TW), .off_width(OW)) bus ();

  line_fetch_engine #(
    .addr_width(AW), .list_depth(LD), .data_width(DW), .list_width(LW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] lmem    [0:NW-1];
  logic [DW-1:0] ref_mem [0:NW-1];
  logic [DW-1:0] rdq[$];
  logic [DW-1:0] exp_wb[$];
  bit            req_we_q[$];
  logic [AW-1:0] req_addr_q[$];
  logic [DW-1:0] wb_data_q[$];
  bit            wb_last_q[$];
  int            wb_cyc_q[$];
  int            done_cyc_q[$];
  int            rd_acc, wr_low, wr_stall_left;
  int            rq_mode, wd_mode, wr_mode, rv_mode;
  bit            extra_rv, s5, s17, wd_tog, pend_v;
  logic [TW+OW-1:0] pend_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Environment: observe at negedge, drive inputs just after posedge.
  always begin
    @(negedge clk);
    if (rst) begin
      pend_v = 1'b0;
    end else begin
      chk("rdata_ready_without_wready", 64'(bus.ext_rdata_ready && !bus.mem_wready), 64'(0));
      if (bus.ext_req_valid && bus.ext_req_ready) begin
        req_we_q.push_back(bus.ext_req_we);
        req_addr_q.push_back(bus.ext_req_addr);
      end
      if (bus.ext_wdata_valid && bus.ext_wdata_ready) begin
        wb_data_q.push_back(bus.ext_wdata);
        wb_last_q.push_back(bus.ext_wdata_last);
        wb_cyc_q.push_back(cyc);
      end
      if (bus.mem_wen && bus.mem_wready) lmem[bus.mem_waddr] = bus.mem_wdata;
      if (bus.ext_rdata_valid && bus.ext_rdata_ready) begin
        if (rdq.size() > 0) void'(rdq.pop_front());
        rd_acc++;
      end
      if (bus.fetch_done) done_cyc_q.push_back(cyc);
      pend_v = bus.mem_ren;
      pend_a = bus.mem_raddr;
    end
    @(posedge clk);
    #1;
    bus.mem_rdata     = pend_v ? lmem[pend_a] : $urandom();
    bus.ext_req_ready = (rq_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    wd_tog = ~wd_tog;
    case (wd_mode)
      0:       bus.ext_wdata_ready = 1'b1;
      1:       bus.ext_wdata_ready = wd_tog;
      default: bus.ext_wdata_ready = 1'($urandom_range(0, 1));
    endcase
    if (rdq.size() > 0) begin
      bus.ext_rdata_valid = (rv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.ext_rdata       = rdq[0];
    end else begin
      bus.ext_rdata_valid = extra_rv;
      bus.ext_rdata       = $urandom();
    end
    case (wr_mode)
      0: bus.mem_wready = 1'b1;
      1: bus.mem_wready = 1'($urandom_range(0, 1));
      default: begin
        if (wr_stall_left > 0) begin
          wr_stall_left--;
          bus.mem_wready = 1'b0;
        end else if ((rd_acc == 5 && !s5) || (rd_acc == 17 && !s17)) begin
          if (rd_acc == 5) s5 = 1'b1;
          else s17 = 1'b1;
          wr_stall_left = 2;
          bus.mem_wready = 1'b0;
        end else begin
          bus.mem_wready = 1'b1;
        end
        if (!bus.mem_wready) wr_low++;
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, 64'({bus.fetch_gnt, bus.fetch_done, bus.ext_req_valid, bus.ext_req_we,
                  bus.ext_wdata_valid, bus.ext_wdata_last, bus.ext_rdata_ready,
                  bus.mem_ren, bus.mem_wen}), 64'(0));
    chk({tag, "_addr"}, 64'({bus.ext_req_addr, bus.mem_waddr, bus.mem_raddr}), 64'(0));
  endtask

  // Reference model: whole-line view of what the command must do.
  task automatic prep(input logic [1:0] cmd, input logic [TW-1:0] tag, input bit idx_data);
    logic [DW-1:0] w;
    int base;
    base = int'(tag) * LW;
    req_we_q.delete(); req_addr_q.delete(); wb_data_q.delete(); wb_last_q.delete();
    wb_cyc_q.delete(); done_cyc_q.delete(); rdq.delete(); exp_wb.delete();
    rd_acc = 0; wr_low = 0; wr_stall_left = 0; s5 = 1'b0; s17 = 1'b0;
    for (int i = 0; i < NW; i++) ref_mem[i] = lmem[i];
    for (int i = 0; i < LW; i++) begin
      if (cmd[1]) exp_wb.push_back(lmem[base + i]);
      if (cmd[0]) begin
        w = idx_data ? DW'(i) : DW'($urandom());
        rdq.push_back(w);
        ref_mem[base + i] = w;
      end
    end
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [TW-1:0] tag,
                       input logic [AW-1:0] addr, input logic [AW-1:0] pre, output int t0);
    bus.fetch_req      = 1'b1;
    bus.fetch_cmd      = cmd;
    bus.fetch_tag      = tag;
    bus.fetch_addr     = addr;
    bus.fetch_addr_pre = pre;
    @(negedge clk);
    chk("gnt_when_idle", 64'(bus.fetch_gnt), 64'(1));
    t0 = cyc;
    tick();
    bus.fetch_req = 1'b0;
  endtask

  task automatic finish_op(input logic [1:0] cmd, input logic [AW-1:0] addr,
                           input logic [AW-1:0] pre, input int t0, input bit burst,
                           output int lat);
    int n, k, mism, exp_n;
    n = 0;
    while (done_cyc_q.size() == 0 && n < 4000) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done_cyc_q.size() != 0), 64'(1));
    repeat (3) tick();
    chk("done_once", 64'(done_cyc_q.size()), 64'(1));
    lat = (done_cyc_q.size() != 0) ? done_cyc_q[0] - t0 : -1;
    exp_n = int'(cmd[1]) + int'(cmd[0]);
    chk("req_count", 64'(req_we_q.size()), 64'(exp_n));
    if (req_we_q.size() == exp_n) begin
      k = 0;
      if (cmd[1]) begin
        chk("wb_req_we", 64'(req_we_q[0]), 64'(1));
        chk("wb_req_addr", 64'(req_addr_q[0]), 64'(pre));
        k = 1;
      end
      if (cmd[0]) begin
        chk("rd_req_we", 64'(req_we_q[k]), 64'(0));
        chk("rd_req_addr", 64'(req_addr_q[k]), 64'(addr));
      end
    end
    chk("wb_beats", 64'(wb_data_q.size()), 64'(cmd[1] ? LW : 0));
    if (cmd[1] && wb_data_q.size() == LW) begin
      for (int i = 0; i < LW; i++) begin
        chk("wb_data", 64'(wb_data_q[i]), 64'(exp_wb[i]));
        chk("wb_last", 64'(wb_last_q[i]), 64'(i == LW - 1));
      end
      if (burst) chk("wb_burst_span", 64'(wb_cyc_q[LW-1] - wb_cyc_q[0]), 64'(LW - 1));
    end
    chk("rd_beats", 64'(rd_acc), 64'(cmd[0] ? LW : 0));
    mism = 0;
    for (int i = 0; i < NW; i++) if (lmem[i] !== ref_mem[i]) mism++;
    chk("line_mem_image", 64'(mism), 64'(0));
  endtask

  task automatic run_op(input logic [1:0] cmd, input logic [TW-1:0] tag,
                        input logic [AW-1:0] addr, input logic [AW-1:0] pre,
                        input bit idx_data, input bit burst, output int lat);
    int t0;
    prep(cmd, tag, idx_data);
    issue(cmd, tag, addr, pre, t0);
    finish_op(cmd, addr, pre, t0, burst, lat);
  endtask

  initial begin
    int lat, t0, n;
    logic [1:0] rc;
    rst = 1'b1;
    bus.fetch_req = 1'b0; bus.fetch_cmd = '0; bus.fetch_tag = '0;
    bus.fetch_addr = '0; bus.fetch_addr_pre = '0;
    rq_mode = 0; wd_mode = 0; wr_mode = 0; rv_mode = 0; extra_rv = 1'b0;
    for (int i = 0; i < NW; i++) lmem[i] = $urandom();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset_outputs");
    tick();
    rst = 1'b0;
    tick();

    // Refill, everything ready: fixed latency to done.
    run_op(2'b01, 2'd2, 32'h1000, 32'h0, 1'b1, 1'b0, lat);
    chk("refill_done_latency", 64'(lat), 64'(LW + 2));

    // Writeback only from a known line, full throughput.
    for (int i = 0; i < LW; i++) lmem[LW + i] = 32'hA0 + i;
    run_op(2'b10, 2'd1, 32'h0, 32'h2000, 1'b0, 1'b1, lat);

    // Writeback then refill with ext_wdata_ready toggling.
    wd_mode = 1;
    run_op(2'b11, 2'd3, 32'h3000, 32'h4000, 1'b0, 1'b0, lat);
    wd_mode = 0;

    // Refill with line-memory back-pressure on beats 5 and 17.
    wr_mode = 2;
    run_op(2'b01, 2'd0, 32'h5000, 32'h0, 1'b0, 1'b0, lat);
    chk("wready_stall_cycles", 64'(wr_low), 64'(6));
    wr_mode = 0;

    // No-op command; stray read beats offered throughout must be refused.
    extra_rv = 1'b1;
    run_op(2'b00, 2'd1, 32'h6000, 32'h7000, 1'b0, 1'b0, lat);
    chk("noop_done_soon", 64'(lat >= 1 && lat <= 2), 64'(1));
    extra_rv = 1'b0;

    // Reset mid-refill, a refused busy request, then a clean refill.
    prep(2'b01, 2'd3, 1'b0);
    issue(2'b01, 2'd3, 32'h9000, 32'h0, t0);
    n = 0;
    while (rd_acc < 3 && n < 200) begin tick(); n++; end
    bus.fetch_req = 1'b1; bus.fetch_cmd = 2'b11; bus.fetch_tag = 2'd0;
    @(negedge clk);
    chk("gnt_when_busy", 64'(bus.fetch_gnt), 64'(0));
    tick();
    bus.fetch_req = 1'b0;
    n = 0;
    while (rd_acc < 10 && n < 200) begin tick(); n++; end
    chk("reached_beat_10", 64'(rd_acc), 64'(10));
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("midop_reset_outputs");
    tick();
    tick();
    rst = 1'b0;
    repeat (40) tick();
    chk("no_done_after_abort", 64'(done_cyc_q.size()), 64'(0));
    run_op(2'b01, 2'd3, 32'h8000, 32'h0, 1'b0, 1'b0, lat);
    chk("refill_after_reset_latency", 64'(lat), 64'(LW + 2));

    // Randomized commands and handshake behaviour.
    for (int it = 0; it < 8; it++) begin
      rq_mode = $urandom_range(0, 1);
      wd_mode = $urandom_range(0, 2);
      wr_mode = $urandom_range(0, 1);
      rv_mode = $urandom_range(0, 1);
      rc = 2'($urandom_range(0, 3));
      run_op(rc, 2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FF80,
             $urandom() & 32'hFFFF_FF80, 1'b0, 1'b0, lat);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
